// File: rtl/draw_engine_pkg.sv
// ============================================================================
//  Module   : draw_pkg (package)
//  Purpose  : Shared definitions for the draw engine: default screen size,
//             colour constants, the operation enum and the background
//             colour function used by the bg and clear operations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package draw_pkg;

  // Default screen geometry
  localparam int c_screen_w = 160;
  localparam int c_screen_h = 120;

  // Fixed-colour operations
  localparam logic [2:0] c_col_menu = 3'b001;
  localparam logic [2:0] c_col_win  = 3'b110;
  localparam logic [2:0] c_col_car  = 3'b100;

  // Background palette
  localparam logic [2:0] c_col_grass = 3'b010;
  localparam logic [2:0] c_col_line  = 3'b111;
  localparam logic [2:0] c_col_road  = 3'b000;

  // The enum value doubles as the bit index into the done vector
  typedef enum logic [2:0] {
    OP_MENU  = 3'd0,
    OP_BG    = 3'd1,
    OP_CAR   = 3'd2,
    OP_WIN   = 3'd3,
    OP_CLEAR = 3'd4
  } op_e;

  // Grass on both sides, a dashed centre line (8 lines on, 8 off) and
  // black road everywhere else. Coordinates are absolute screen positions.
  function automatic logic [2:0] bg_colour(input logic [7:0] x, input logic [6:0] y);
    logic [2:0] col;
    if (x < 8'd32 || x >= 8'd128) begin
      col = c_col_grass;
    end else if (x >= 8'd78 && x <= 8'd81 && !y[3]) begin
      col = c_col_line;
    end else begin
      col = c_col_road;
    end
    return col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/draw_engine_if.sv
// ============================================================================
//  Module   : draw_engine_if (interface)
//  Purpose  : Control/pixel bundle between the game controller and the draw
//             engine.
//             master : controller side  - drives requests and car origin
//             slave  : engine side      - drives pixel bus, done flags,
//                                         busy and the frame tick
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface draw_engine_if;

  // Requests (level) and car origin
  logic       draw_menu;
  logic       draw_bg;
  logic       draw_car;
  logic       draw_win;
  logic       clear;
  logic [7:0] car_x;
  logic [6:0] car_y;

  // VGA adapter pixel write
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  // Completion / status
  logic       done_menu;
  logic       done_bg;
  logic       done_car;
  logic       done_win;
  logic       done_clear;
  logic       busy;
  logic       oneframe;

  modport master (
    output draw_menu, draw_bg, draw_car, draw_win, clear, car_x, car_y,
    input  x, y, colour, plot,
    input  done_menu, done_bg, done_car, done_win, done_clear, busy, oneframe
  );

  modport slave (
    input  draw_menu, draw_bg, draw_car, draw_win, clear, car_x, car_y,
    output x, y, colour, plot,
    output done_menu, done_bg, done_car, done_win, done_clear, busy, oneframe
  );

endinterface

`default_nettype wire

// File: rtl/draw_engine_frame_tick.sv
// ============================================================================
//  Module   : frame_tick
//  Purpose  : Free-running frame period counter; emits a one-cycle pulse
//             every FRAME_CYCLES clocks, counting from reset release.
//  Ports    : clock    in  1  rising-edge clock
//             reset    in  1  asynchronous active-low reset
//             oneframe out 1  registered frame pulse
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_tick #(
  parameter int FRAME_CYCLES = 833334
) (
  input  wire clock,
  input  wire reset,
  output wire oneframe
);

  localparam int c_cnt_w = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAME_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign oneframe = r_tick;

endmodule

`default_nettype wire

// File: rtl/draw_engine.sv
// ============================================================================
//  Module   : draw_engine
//  Purpose  : Rectangle scan engine for a 160x120 VGA adapter. Accepts one
//             level request at a time (menu, bg, car, win, clear), scans its
//             rectangle one pixel per clock in raster order, clips pixels
//             that fall off screen, then holds done_<op> until the request
//             drops (four-phase handshake).
//  Ports    : clock  in   1   rising-edge clock
//             reset  in   1   asynchronous active-low reset
//             bus    slave modport of draw_engine_if:
//                    requests, car_x/car_y in; x/y/colour/plot,
//                    done_*, busy, oneframe out
//  Config   : DRAW_ENGINE_FRAME_TICK_EN - when defined, oneframe pulses every
//             FRAME_CYCLES clocks; otherwise oneframe is tied low.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module draw_engine
  import draw_pkg::*;
#(
  parameter int SCREEN_W     = c_screen_w,
  parameter int SCREEN_H     = c_screen_h,
  parameter int CAR_W        = 8,
  parameter int CAR_H        = 8,
  parameter int FRAME_CYCLES = 833334
) (
  input  wire          clock,
  input  wire          reset,
  draw_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Extents are stored as "last index" so the wrap test is a plain compare
  localparam logic [7:0] c_scr_w_m1 = 8'(SCREEN_W - 1);
  localparam logic [6:0] c_scr_h_m1 = 7'(SCREEN_H - 1);
  localparam logic [7:0] c_car_w_m1 = 8'(CAR_W - 1);
  localparam logic [6:0] c_car_h_m1 = 7'(CAR_H - 1);

  state_e     r_state;
  op_e        r_op;
  logic [7:0] r_org_x;
  logic [6:0] r_org_y;
  logic [7:0] r_last_cx;
  logic [6:0] r_last_cy;
  logic [7:0] r_cx;
  logic [6:0] r_cy;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_busy;
  logic [4:0] r_done;

  op_e        w_sel_op;
  logic       w_req_any;
  logic       w_op_req;
  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic       w_on_screen;
  logic [2:0] w_colour;

  // Fixed priority: clear > car > bg > win > menu
  always_comb begin
    w_sel_op = OP_MENU;
    if (bus.clear)          w_sel_op = OP_CLEAR;
    else if (bus.draw_car)  w_sel_op = OP_CAR;
    else if (bus.draw_bg)   w_sel_op = OP_BG;
    else if (bus.draw_win)  w_sel_op = OP_WIN;
  end

  assign w_req_any = bus.clear | bus.draw_car | bus.draw_bg | bus.draw_win | bus.draw_menu;

  // Request line belonging to the latched operation, used to end DONE
  always_comb begin
    w_op_req = 1'b0;
    case (r_op)
      OP_MENU:  w_op_req = bus.draw_menu;
      OP_BG:    w_op_req = bus.draw_bg;
      OP_CAR:   w_op_req = bus.draw_car;
      OP_WIN:   w_op_req = bus.draw_win;
      OP_CLEAR: w_op_req = bus.clear;
      default:  w_op_req = 1'b0;
    endcase
  end

  // One extra bit of headroom so a car near the right/bottom edge clips
  // instead of wrapping back onto the screen
  assign w_sx        = {1'b0, r_org_x} + {1'b0, r_cx};
  assign w_sy        = {1'b0, r_org_y} + {1'b0, r_cy};
  assign w_on_screen = (w_sx < 9'(SCREEN_W)) && (w_sy < 8'(SCREEN_H));

  always_comb begin
    w_colour = c_col_menu;
    case (r_op)
      OP_MENU:  w_colour = c_col_menu;
      OP_WIN:   w_colour = c_col_win;
      OP_CAR:   w_colour = c_col_car;
      OP_BG,
      OP_CLEAR: w_colour = bg_colour(w_sx[7:0], w_sy[6:0]);
      default:  w_colour = c_col_menu;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MENU;
      r_org_x   <= '0;
      r_org_y   <= '0;
      r_last_cx <= '0;
      r_last_cy <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          r_busy <= 1'b0;
          r_done <= '0;
          if (w_req_any) begin
            r_op  <= w_sel_op;
            r_cx  <= '0;
            r_cy  <= '0;
            if (w_sel_op == OP_CAR || w_sel_op == OP_CLEAR) begin
              r_org_x   <= bus.car_x;
              r_org_y   <= bus.car_y;
              r_last_cx <= c_car_w_m1;
              r_last_cy <= c_car_h_m1;
            end else begin
              r_org_x   <= '0;
              r_org_y   <= '0;
              r_last_cx <= c_scr_w_m1;
              r_last_cy <= c_scr_h_m1;
            end
            r_state <= S_SCAN;
          end
        end

        // Pixel outputs and busy are registered together so busy frames
        // exactly the cycles on which a pixel is presented
        S_SCAN: begin
          r_x      <= w_sx[7:0];
          r_y      <= w_sy[6:0];
          r_colour <= w_colour;
          r_plot   <= w_on_screen;
          r_busy   <= 1'b1;
          if (r_cx == r_last_cx) begin
            r_cx <= '0;
            if (r_cy == r_last_cy) begin
              r_state <= S_DONE;
            end else begin
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end

        // First DONE cycle always raises done, so it is visible even if the
        // request was dropped mid-scan; afterwards wait for request low
        S_DONE: begin
          r_plot <= 1'b0;
          r_busy <= 1'b0;
          if (r_done == '0) begin
            r_done <= 5'd1 << r_op;
          end else if (!w_op_req) begin
            r_done  <= '0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.colour     = r_colour;
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.done_menu  = r_done[0];
  assign bus.done_bg    = r_done[1];
  assign bus.done_car   = r_done[2];
  assign bus.done_win   = r_done[3];
  assign bus.done_clear = r_done[4];

`ifdef DRAW_ENGINE_FRAME_TICK_EN
  wire w_oneframe;

  frame_tick #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_frame_tick (
    .clock    (clock),
    .reset    (reset),
    .oneframe (w_oneframe)
  );

  assign bus.oneframe = w_oneframe;
`else
  assign bus.oneframe = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_draw_engine.sv
// ============================================================================
//  Module   : tb_draw_engine
//  Purpose  : Self-checking bench for draw_engine: table of scan operations
//             plus hand-written reset, priority and reset-mid-scan sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_draw_engine;
  import draw_pkg::*;

  localparam int SW = 160;
  localparam int SH = 120;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  draw_engine_if bus ();

  draw_engine #(
    .SCREEN_W     (SW),
    .SCREEN_H     (SH),
    .CAR_W        (8),
    .CAR_H        (8),
    .FRAME_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- frame tick monitor ----------------
  int g_cyc = 0;
  int last_pulse = -1;
  int n_pulse = 0;
  int bad_gap = 0;

  always @(posedge clock) g_cyc <= g_cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      last_pulse = -1;
    end else if (bus.oneframe === 1'b1) begin
      n_pulse++;
      if (last_pulse >= 0 && (g_cyc - last_pulse) != 4) bad_gap++;
      last_pulse = g_cyc;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_colour(input op_e op, input int x, input int y);
    if (op == OP_MENU) return 3'b001;
    if (op == OP_WIN)  return 3'b110;
    if (op == OP_CAR)  return 3'b100;
    if (x < 32 || x >= 128) return 3'b010;
    if (x >= 78 && x <= 81 && ((y / 8) % 2) == 0) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic get_done(input op_e op);
    case (op)
      OP_MENU:  return bus.done_menu;
      OP_BG:    return bus.done_bg;
      OP_CAR:   return bus.done_car;
      OP_WIN:   return bus.done_win;
      default:  return bus.done_clear;
    endcase
  endfunction

  task automatic set_req(input op_e op, input logic v);
    case (op)
      OP_MENU:  bus.draw_menu = v;
      OP_BG:    bus.draw_bg   = v;
      OP_CAR:   bus.draw_car  = v;
      OP_WIN:   bus.draw_win  = v;
      default:  bus.clear     = v;
    endcase
  endtask

  typedef struct {
    op_e        op;
    logic [7:0] cx;
    logic [6:0] cy;
    int         exp_plots;
    int         exp_done;
    int         exp_white;   // plotted pixels of colour 3'b111
  } vec_t;

  // Runs one operation from request to handshake completion
  task automatic run_vec(input vec_t v, input string tag);
    int w, h, ox, oy, p, plots, bad, white, donec, cyc, sx, sy, hold_bad, other;
    logic       exp_plot;
    logic [7:0] last_x;
    logic [6:0] last_y;
    bool_small: begin end
    w  = (v.op == OP_CAR || v.op == OP_CLEAR) ? 8 : SW;
    h  = (v.op == OP_CAR || v.op == OP_CLEAR) ? 8 : SH;
    ox = (v.op == OP_CAR || v.op == OP_CLEAR) ? int'(v.cx) : 0;
    oy = (v.op == OP_CAR || v.op == OP_CLEAR) ? int'(v.cy) : 0;
    p = 0; plots = 0; bad = 0; white = 0; donec = -1; cyc = 0; other = 0;
    last_x = '0; last_y = '0;

    @(negedge clock);
    bus.car_x = v.cx;
    bus.car_y = v.cy;
    set_req(v.op, 1'b1);
    @(posedge clock);              // accept edge, cycle 0
    #1;
    bus.car_x = ~v.cx;             // origin must already be latched
    bus.car_y = ~v.cy;

    while (cyc < 20000) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (get_done(v.op) === 1'b1) begin
        donec = cyc;
        break;
      end
      if (bus.busy === 1'b1) begin
        sx = ox + (p % w);
        sy = oy + (p / w);
        exp_plot = (sx < SW) && (sy < SH);
        if (bus.x !== 8'(sx) || bus.y !== 7'(sy) || bus.plot !== exp_plot) bad++;
        else if (exp_plot && bus.colour !== ref_colour(v.op, sx, sy)) bad++;
        if (bus.plot === 1'b1) plots++;
        if (bus.plot === 1'b1 && bus.colour === 3'b111) white++;
        last_x = 8'(sx);
        last_y = 7'(sy);
        p++;
      end
    end
    other = int'({bus.done_menu, bus.done_bg, bus.done_car, bus.done_win, bus.done_clear})
            - (32'd1 << (4 - int'(v.op)));

    check({tag, "_done_cycle"}, donec, v.exp_done);
    check({tag, "_scan_cycles"}, p, w * h);
    check({tag, "_plots"}, plots, v.exp_plots);
    check({tag, "_pixels_bad"}, bad, 0);
    check({tag, "_white"}, white, v.exp_white);
    check({tag, "_other_done"}, other, 0);

    hold_bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (get_done(v.op) !== 1'b1 || bus.busy !== 1'b0 || bus.plot !== 1'b0 ||
          bus.x !== last_x || bus.y !== last_y) hold_bad++;
    end
    check({tag, "_done_hold"}, hold_bad, 0);

    set_req(v.op, 1'b0);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_done_release"}, {get_done(v.op), bus.busy}, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    logic saw;
    vec_t bgv;

    bus.draw_menu = 0; bus.draw_bg = 0; bus.draw_car = 0;
    bus.draw_win = 0; bus.clear = 0; bus.car_x = 0; bus.car_y = 0;

    vecs[0] = '{OP_CAR,   8'd10,  7'd20,  64,    65,    0};
    vecs[1] = '{OP_CLEAR, 8'd76,  7'd4,   64,    65,    16};
    vecs[2] = '{OP_CAR,   8'd156, 7'd0,   32,    65,    0};
    vecs[3] = '{OP_CAR,   8'd156, 7'd116, 16,    65,    0};
    vecs[4] = '{OP_CLEAR, 8'd0,   7'd116, 32,    65,    0};
    vecs[5] = '{OP_MENU,  8'd0,   7'd0,   19200, 19201, 0};

    // ---- reset state ----
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs",
          {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done_menu, bus.done_bg,
           bus.done_car, bus.done_win, bus.done_clear, bus.oneframe}, 0);
    @(posedge clock); #2 reset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("idle_outputs",
          {bus.plot, bus.busy, bus.done_menu, bus.done_bg, bus.done_car,
           bus.done_win, bus.done_clear}, 0);

    // ---- table-driven scans ----
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // ---- clear and draw_car in the same cycle ----
    @(negedge clock);
    bus.car_x = 8'd0; bus.car_y = 7'd0;
    bus.clear = 1'b1; bus.draw_car = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("prio_first_colour", bus.colour, 3'b010);
    n = 0;
    while (n < 200 && bus.done_clear !== 1'b1 && bus.done_car !== 1'b1) begin
      @(negedge clock); n++;
    end
    check("prio_done_pair", {bus.done_clear, bus.done_car}, 2'b10);
    repeat (2) @(negedge clock);
    check("prio_car_waits", {bus.busy, bus.done_clear}, 2'b01);
    bus.clear = 1'b0;
    n = 0; saw = 0;
    while (n < 20) begin
      @(negedge clock); n++;
      if (bus.busy === 1'b1) begin saw = 1; break; end
    end
    check("prio_car_started", saw, 1'b1);
    check("prio_car_colour", {bus.colour, bus.x, bus.y}, {3'b100, 8'd0, 7'd0});
    n = 0;
    while (n < 200 && bus.done_car !== 1'b1) begin @(negedge clock); n++; end
    check("prio_car_done", bus.done_car, 1'b1);
    bus.draw_car = 1'b0;
    repeat (3) @(negedge clock);

    // ---- reset in the middle of a bg scan ----
    bus.draw_bg = 1'b1;
    n = 0; saw = 0;
    while (n < 300) begin
      @(negedge clock); n++;
      if (bus.busy === 1'b1 && bus.x === 8'd100 && bus.y === 7'd0) begin saw = 1; break; end
    end
    check("bg_reached_px100", saw, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midscan_reset_outputs",
          {bus.plot, bus.busy, bus.x, bus.y, bus.colour, bus.done_bg}, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    bgv = '{OP_BG, 8'd0, 7'd0, 19200, 19201, 256};
    run_vec(bgv, "bg_restart");

    // ---- frame tick ----
`ifdef DRAW_ENGINE_FRAME_TICK_EN
    check("frame_tick_pulses_seen", (n_pulse > 100), 1'b1);
    check("frame_tick_gap_bad", bad_gap, 0);
`else
    check("oneframe_pulses", n_pulse, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/draw_engine.md
DRAW_ENGINE -- requirements
Module: draw_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 SHALL have parameters CAR_W and CAR_H, default 8 each, car sprite size.
REQ-004 SHALL have parameter FRAME_CYCLES, default 833334, oneframe period in clocks.
REQ-005 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: draw_menu, draw_bg, draw_car, draw_win, clear  in  1 each  level requests from control.
REQ-008 SHALL have ports: car_x  in  8, car_y  in  7  car origin, sampled at accept.
REQ-009 SHALL have ports: x  out  8, y  out  7, colour  out  3, plot  out  1  VGA adapter pixel write.
REQ-010 SHALL have ports: done_menu, done_bg, done_car, done_win, done_clear  out  1 each  completion per request.
REQ-011 SHALL have ports: busy  out  1 (scan in progress), oneframe  out  1 (frame tick pulse).

Function
REQ-012 SHALL implement FSM IDLE, SCAN, DONE, registered outputs.
REQ-013 IDLE: any request high -> latch op, origin and extent, clear counters cx=cy=0, go SCAN; priority clear > draw_car > draw_bg > draw_win > draw_menu.
REQ-014 Extent: menu/bg/win full screen, origin (0,0); car/clear CAR_W x CAR_H at (car_x,car_y).
REQ-015 SCAN: one pixel per cycle, raster order; x=origin_x+cx, y=origin_y+cy; cx wraps at width-1 and increments cy; after (width-1,height-1) go DONE.
REQ-016 plot SHALL be 1 during SCAN, except 0 for pixels with x>=SCREEN_W or y>=SCREEN_H (clipped); clipped pixels still consume a cycle.
REQ-017 Latency: accept at cycle 0, pixels on cycles 1..W*H, done_<op> high from cycle W*H+1.
REQ-018 DONE: done_<latched op> held high until its request is low, then IDLE (four-phase handshake); DONE lasts at least one cycle.
REQ-019 Request deasserted or changed during SCAN SHALL be ignored; latched car_x/car_y unaffected by input changes.
REQ-020 Colours: menu 3'b001; win 3'b110; car 3'b100; bg and clear use bg_colour(x,y) at absolute coordinates.
REQ-021 bg_colour: 3'b010 if x<32 or x>=128; else 3'b111 if 78<=x<=81 and y[3]==0; else 3'b000.
REQ-022 busy SHALL equal (state==SCAN); x, y, colour hold last value outside SCAN.

Reset
REQ-023 reset low SHALL immediately force IDLE; plot, busy, all done_*, oneframe, x, y, colour, counters to 0.
REQ-024 Reset mid-scan SHALL abandon the scan; no done issued; a still-held request restarts from (0,0) after release.

Configuration
REQ-025 Macro DRAW_ENGINE_FRAME_TICK_EN defined: oneframe SHALL pulse high one cycle every FRAME_CYCLES clocks, free-running from reset.
REQ-026 Macro undefined: oneframe SHALL be tied 0, no frame counter synthesised; port retained.

Structure
REQ-027 Package draw_pkg SHALL hold SCREEN_W/H defaults, colour constants, op enum (OP_MENU, OP_BG, OP_CAR, OP_WIN, OP_CLEAR) and function bg_colour.
REQ-028 Frame counter SHALL be sub-module frame_tick (parameter FRAME_CYCLES, outputs oneframe), instantiated only under the macro.

Verification
REQ-029 Reset pulse, no requests -> all outputs 0, busy 0, stays IDLE.
REQ-030 draw_car, car_x=10, car_y=20 -> 64 plots, x 10..17, y 20..27, colour 3'b100, raster order; done_car at cycle 65, held until draw_car low.
REQ-031 clear, car_x=76, car_y=4 -> x 78..81: colour 3'b111 for y 4..7, 3'b000 for y 8..11; x 76..77 and 82..83 colour 3'b000; done_clear.
REQ-032 clear and draw_car asserted same cycle -> clear scanned first; draw_car accepted only after clear released and DONE exits.
REQ-033 draw_car, car_x=156 -> 32 plots (x 156..159), 64 SCAN cycles, done_car at cycle 65.
REQ-034 reset low at pixel 100 of draw_bg, draw_bg held -> plot 0 immediately; after release scan restarts at (0,0); with macro and FRAME_CYCLES=4, oneframe pulses every 4th cycle.
